// File: rtl/figuras_pkg.sv
// Shared shape codes, debounce state encoding and selection-step helpers
// used by the selector, the shape multiplexer and the shape generators.
package figuras_pkg;

  localparam logic [1:0] FIG_CUADRADO = 2'b00;
  localparam logic [1:0] FIG_CIRCULO  = 2'b01;
  localparam logic [1:0] FIG_RECTA    = 2'b10;

  typedef enum logic [1:0] {
    ESPERA_ALTO   = 2'b00,
    CONFIRMA_ALTO = 2'b01,
    ESPERA_BAJO   = 2'b10,
    CONFIRMA_BAJO = 2'b11
  } deb_state_e;

  // Forward step; an illegal code recovers to FIG_CUADRADO.
  function automatic logic [1:0] fig_siguiente(input logic [1:0] fig);
    logic [1:0] res;
    case (fig)
      FIG_CUADRADO: res = FIG_CIRCULO;
      FIG_CIRCULO:  res = FIG_RECTA;
      FIG_RECTA:    res = FIG_CUADRADO;
      default:      res = FIG_CUADRADO;
    endcase
    return res;
  endfunction

  function automatic logic [1:0] fig_anterior(input logic [1:0] fig);
    logic [1:0] res;
    case (fig)
      FIG_CUADRADO: res = FIG_RECTA;
      FIG_CIRCULO:  res = FIG_CUADRADO;
      FIG_RECTA:    res = FIG_CIRCULO;
      default:      res = FIG_CUADRADO;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/antirrebote.sv
// Two-flop synchroniser plus debounce FSM for one push-button; emits a single
// registered one-cycle pulse per accepted press, nothing on release.
module antirrebote
  import figuras_pkg::*;
#(
  parameter int DEB_CYCLES = 500000,
  parameter int CNT_W      = 19
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic pulso
);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  deb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulso_q, pulso_d;

  // State register: synchroniser, FSM, counter and pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      state_q <= ESPERA_ALTO;
      cnt_q   <= CNT_ZERO;
      pulso_q <= 1'b0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulso_q <= pulso_d;
    end
  end

  // Next-state logic; any sample against the expected level restarts confirmation.
  always_comb begin
    s1_d    = btn;
    s2_d    = s1_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    pulso_d = 1'b0;
    case (state_q)
      ESPERA_ALTO: begin
        if (s2_q) begin
          state_d = CONFIRMA_ALTO;
          cnt_d   = CNT_ZERO;
        end else begin
          state_d = ESPERA_ALTO;
        end
      end
      CONFIRMA_ALTO: begin
        if (!s2_q) begin
          state_d = ESPERA_ALTO;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == CNT_MAX) begin
          state_d = ESPERA_BAJO;
          pulso_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ESPERA_BAJO: begin
        if (!s2_q) begin
          state_d = CONFIRMA_BAJO;
          cnt_d   = CNT_ZERO;
        end else begin
          state_d = ESPERA_BAJO;
        end
      end
      CONFIRMA_BAJO: begin
        if (s2_q) begin
          state_d = ESPERA_BAJO;
        end else if (cnt_q == CNT_MAX) begin
          state_d = ESPERA_ALTO;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ESPERA_ALTO;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  assign pulso = pulso_q;

endmodule

// File: rtl/selector_figura.sv
// Front-panel shape selector: debounces next/previous buttons and keeps the
// registered shape code plus a one-cycle change strobe.
module selector_figura
  import figuras_pkg::*;
#(
  parameter int DEB_CYCLES = 500000,
  parameter int CNT_W      = 19
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_sig,
  input  logic       btn_ant,
  output logic [1:0] selec,
  output logic       cambio
);

  logic       pulso_sig;
  logic       pulso_ant;
  logic [1:0] selec_q, selec_d;
  logic       cambio_q, cambio_d;

  antirrebote #(
    .DEB_CYCLES(DEB_CYCLES),
    .CNT_W     (CNT_W)
  ) u_deb_sig (
    .clk  (clk),
    .reset(reset),
    .btn  (btn_sig),
    .pulso(pulso_sig)
  );

  antirrebote #(
    .DEB_CYCLES(DEB_CYCLES),
    .CNT_W     (CNT_W)
  ) u_deb_ant (
    .clk  (clk),
    .reset(reset),
    .btn  (btn_ant),
    .pulso(pulso_ant)
  );

  // Selection and change-strobe registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      selec_q  <= FIG_CUADRADO;
      cambio_q <= 1'b0;
    end else begin
      selec_q  <= selec_d;
      cambio_q <= cambio_d;
    end
  end

  // Simultaneous pulses cancel; the step helpers map a corrupted 11 to 00.
  always_comb begin
    selec_d  = selec_q;
    cambio_d = 1'b0;
    if (pulso_sig && !pulso_ant) begin
      selec_d  = fig_siguiente(selec_q);
      cambio_d = 1'b1;
    end else if (pulso_ant && !pulso_sig) begin
      selec_d  = fig_anterior(selec_q);
      cambio_d = 1'b1;
    end else begin
      selec_d  = selec_q;
      cambio_d = 1'b0;
    end
  end

  assign selec  = selec_q;
  assign cambio = cambio_q;

endmodule

// File: doc/selector_figura.md
# selector_figura

Front-panel selection stage for the shape-drawing datapath. Takes two raw push-buttons (next/previous), synchronises and debounces them, and maintains the registered 2-bit shape-select code that drives the shape multiplexer's `selec` input. Also emits a one-cycle `cambio` pulse whenever the selection changes, so downstream drawing logic can restart a frame.

## Interface
- `DEB_CYCLES`, default 500000: number of consecutive stable synchronised samples needed to accept a press or release (10 ms at 50 MHz). Legal range is ≥ 2.
- `CNT_W`, default 19: debounce counter width. Must satisfy 2^CNT_W ≥ DEB_CYCLES.

Ports:
- `clk` in 1: system clock. One clock; all logic on its rising edge.
- `reset` in 1: reset, synchronous and active-high.
- `btn_sig` in 1: raw, asynchronous, bouncing "next shape" button, active-high.
- `btn_ant` in 1: raw, asynchronous, bouncing "previous shape" button, active-high.
- `selec` out 2: registered shape code. 00 = cuadrado, 01 = circulo, 10 = recta. 11 is never driven.
- `cambio` out 1: registered. High for exactly one cycle, in the same cycle that `selec` takes a new value.

## Operation
- Each button passes through a 2-flop synchroniser (`s1`, `s2`) and then a per-button debounce FSM with a counter of width `CNT_W`.
- Debounce FSM states and transitions:
  - ESPERA_ALTO: if `s2`=1, go to CONFIRMA_ALTO and set cnt←0.
  - CONFIRMA_ALTO:
    - If `s2`=0, go to ESPERA_ALTO and set cnt←0 (bounce rejected).
    - Else if cnt = DEB_CYCLES−1, go to ESPERA_BAJO and register `pulso`←1 for one cycle.
    - Else cnt←cnt+1.
  - ESPERA_BAJO: if `s2`=0, go to CONFIRMA_BAJO and set cnt←0.
  - CONFIRMA_BAJO:
    - If `s2`=1, go to ESPERA_BAJO.
    - Else if cnt = DEB_CYCLES−1, go to ESPERA_ALTO.
    - Else cnt←cnt+1.
    - No pulse is produced on release.
- A held button yields exactly one pulse. There is no auto-repeat.
- Selection register behaviour, per cycle:
  - `pulso_sig` only: step forward 00→01→10→00 (wraps).
  - `pulso_ant` only: step backward 00→10→01→00 (wraps).
  - Both in the same cycle: no change, and `cambio` stays 0.
  - Neither: hold.
- `cambio`←1 exactly when `selec` is loaded with a new value, otherwise 0.
- If `selec` is ever found at 11 (e.g. SEU), the next pulse in either direction loads 00.
- Reset clears the synchronisers, counters and `pulso` registers, puts both FSMs in ESPERA_ALTO, and sets `selec`=00 and `cambio`=0.
- A button still held when reset deasserts is treated as a fresh press and produces one pulse after the normal latency.

## Timing
- Let edge t0 be the first rising edge at which the raw button is sampled high and it stays high. Then:
  - `s2`=1 after edge t0+1.
  - The FSM enters CONFIRMA_ALTO at edge t0+2.
  - `pulso` is high after edge t0+2+DEB_CYCLES.
  - `selec` and `cambio` update at edge t0+3+DEB_CYCLES.
- Press-to-`selec` latency is therefore DEB_CYCLES+3 clocks.
- Any low sample inside the confirm window restarts the count. The full DEB_CYCLES stable samples are always required.
- Minimum press-to-press interval is about 2·DEB_CYCLES+4 clocks: a release must be confirmed before the next press is accepted.
- Reset has priority over every other event in the same cycle.

## Structure
- Shared package `figuras_pkg` holds:
  - Shape codes `FIG_CUADRADO`=2'b00, `FIG_CIRCULO`=2'b01, `FIG_RECTA`=2'b10.
  - Debounce state encodings (2 bits).
- The shape multiplexer and the shape generators import the same codes.
- Sub-module `antirrebote` contains synchroniser + FSM + counter, with ports `clk`, `reset`, `btn`, `pulso` and parameters `DEB_CYCLES`, `CNT_W`. `selector_figura` instantiates it twice and adds the selection register.

## Test plan
All scenarios use DEB_CYCLES=4, CNT_W=3. Press latency is 7 clocks.
- Reset, then hold `btn_sig` high for 20 cycles → `selec` goes 00→01 at edge t0+7 with one `cambio` pulse, and does not change again while held.
- `btn_sig` chatter (1,0,1,1,0 per cycle) followed by 10 stable high cycles → exactly one step, occurring 7 clocks after the last rising sample.
- Three clean `btn_sig` presses, each followed by ≥6 low cycles → `selec` goes 01, 10, 00 (wrap), with three `cambio` pulses.
- From `selec`=00, one `btn_ant` press → `selec`=10. A second press → `selec`=01.
- Both buttons pressed on the same cycle → both pulses coincide, `selec` is unchanged and `cambio` stays 0.
- Assert `reset` mid-count with `selec`=10 while `btn_sig` is held → `selec`=00 and `cambio`=0 the cycle after reset. With the button still held after reset deasserts, `selec`=01 appears 7 clocks later.
